// File: rtl/array_drain.sv
// array_drain: deskews systolic-array bottom outputs into whole rows, buffers them in a FIFO, frames them (optional ReLU: ARRAY_DRAIN_RELU_EN).
// Latency: in_valid at cycle t -> out_valid at t+COLUMN_NUMBER when the FIFO is empty.
// Backpressure: out_ready stalls only the FIFO head; the skew path never stalls, and rows arriving at a full FIFO are dropped (overflow).
module array_drain #(
    parameter int COLUMN_NUMBER = 256,
    parameter int FIFO_DEPTH    = 4,
    parameter int ROW_CNT_W     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_start,
    input  logic [ROW_CNT_W-1:0]            cmd_rows,
    input  logic                            in_valid,
    input  logic [0:COLUMN_NUMBER-1][7:0]   down_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [0:COLUMN_NUMBER-1][7:0]   out_data,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [ROW_CNT_W-1:0] rows, entered, written, written_inc;
    logic                 entry;
    logic [COLUMN_NUMBER-2:0] vpipe;
    logic                 row_push, row_last;
    logic [0:COLUMN_NUMBER-1][7:0] aligned, wr_row;

    logic [0:COLUMN_NUMBER-1][7:0] mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full, pop, push_ok;

    assign entry = in_valid && (state == CAPTURE) && (entered < rows);

    // Lane j arrives j cycles late, so it is delayed by the complementary amount.
    for (genvar j = 0; j < COLUMN_NUMBER; j++) begin : g_lane
        localparam int D = COLUMN_NUMBER - 1 - j;
        if (D == 0) begin : g_direct
            assign aligned[j] = down_in[j];
        end else begin : g_delay
            logic [D-1:0][7:0] sr;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else begin
                    sr[0] <= down_in[j];
                    for (int k = 1; k < D; k++) begin
                        sr[k] <= sr[k-1];
                    end
                end
            end
            assign aligned[j] = sr[D-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= entry;
            for (int k = 1; k < COLUMN_NUMBER - 1; k++) begin
                vpipe[k] <= vpipe[k-1];
            end
        end
    end

    assign row_push = vpipe[COLUMN_NUMBER-2];

    always_comb begin
        wr_row = aligned;
`ifdef ARRAY_DRAIN_RELU_EN
        for (int j = 0; j < COLUMN_NUMBER; j++) begin
            if (aligned[j][7]) begin
                wr_row[j] = 8'h00;
            end
        end
`endif
    end

    assign written_inc = written + 1'b1;
    assign row_last    = (written_inc == rows);

    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a row when the head leaves on the same edge.
    assign push_ok   = row_push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr]      <= wr_row;
            last_mem[wr_ptr] <= row_last;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;
    assign out_last = out_valid && last_mem[rd_ptr];
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    state_nx = (cmd_rows == '0) ? FLUSH : CAPTURE;
                end
            end
            CAPTURE: begin
                if (written == rows) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (!out_valid && (vpipe == '0)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rows     <= '0;
            entered  <= '0;
            written  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == FLUSH) && (state_nx == IDLE);
            if ((state == IDLE) && cmd_start) begin
                rows     <= cmd_rows;
                entered  <= '0;
                written  <= '0;
                overflow <= 1'b0;
            end else begin
                if (entry) begin
                    entered <= entered + 1'b1;
                end
                // Dropped rows still count so the frame can finish.
                if (row_push) begin
                    written <= written_inc;
                end
                if (row_push && !push_ok) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_array_drain.sv
// Scoreboard bench for array_drain (4 columns, 4-deep FIFO): stimulus queues expected rows, a negedge monitor pops and compares.
module tb_array_drain;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int RW    = 16;

    typedef logic [0:N-1][7:0] row_t;
    typedef struct packed {
        row_t data;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic reset, cmd_start, in_valid, out_valid, out_ready, out_last, busy, done, overflow;
    logic [RW-1:0] cmd_rows;
    row_t down_in, out_data;

    exp_t exp_q[$];
    exp_t mon_e;
    row_t hist[N];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic toggle;
    logic prev_stall = 1'b0;
    row_t prev_data;
    logic prev_last;

    always #5 clk = ~clk;

    array_drain #(.COLUMN_NUMBER(N), .FIFO_DEPTH(DEPTH), .ROW_CNT_W(RW)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_rows(cmd_rows),
        .in_valid(in_valid), .down_in(down_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t relu(input row_t r);
        row_t o;
        o = r;
`ifdef ARRAY_DRAIN_RELU_EN
        for (int j = 0; j < N; j++) begin
            if (r[j][7]) o[j] = 8'h00;
        end
`endif
        return o;
    endfunction

    task automatic expect_row(input row_t r, input logic last);
        exp_t e;
        e.data = relu(r);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; lane j carries the row issued j cycles earlier.
    task automatic step(input logic v, input row_t r);
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v ? r : {N{8'hEE}};
        in_valid = v;
        for (int j = 0; j < N; j++) down_in[j] = hist[j][j];
        if (toggle) out_ready = ~out_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic start(input logic [RW-1:0] n);
        cmd_start = 1'b1;
        cmd_rows  = n;
        step(1'b0, '0);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            step(1'b0, '0);
            n++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(prev_data));
                chk("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_row: got %h expected no row", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("row_data", 64'(out_data), 64'(mon_e.data));
                    chk("row_last", 64'(out_last), 64'(mon_e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;
        int d0;
        reset = 1'b1; cmd_start = 1'b0; cmd_rows = '0; in_valid = 1'b0;
        out_ready = 1'b0; toggle = 1'b0; down_in = '0;
        for (int k = 0; k < N; k++) hist[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        idle(1);

        // Single-row frame: latency and last flag.
        start(1);
        r = {8'h10, 8'h11, 8'h12, 8'h13};
        expect_row(r, 1'b1);
        step(1'b1, r);
        idle(2);
        chk("t1_lat_early", 64'(out_valid), 64'd0);
        idle(1);
        chk("t1_lat", 64'(out_valid), 64'd1);
        chk("t1_last", 64'(out_last), 64'd1);
        d0 = done_cnt;
        out_ready = 1'b1;
        wait_done(d0, 20);
        idle(3);
        chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);

        // Three back-to-back rows with a ready sink.
        start(3);
        for (int i = 0; i < 3; i++) begin
            r = {8'(8'h20 + 8'(i)), 8'(8'h30 + 8'(i)), 8'(8'h40 + 8'(i)), 8'(8'h50 + 8'(i))};
            expect_row(r, i == 2);
            step(1'b1, r);
        end
        idle(1);
        chk("t2_v1", 64'(out_valid), 64'd1);
        idle(1);
        chk("t2_v2", 64'(out_valid), 64'd1);
        idle(1);
        chk("t2_v3", 64'(out_valid), 64'd1);
        idle(1);
        chk("t2_v4", 64'(out_valid), 64'd0);
        d0 = done_cnt;
        wait_done(d0, 20);
        chk("t2_overflow", 64'(overflow), 64'd0);

        // Six rows into a 4-deep FIFO with the sink stalled: rows 5 and 6 drop.
        out_ready = 1'b0;
        start(6);
        for (int i = 0; i < 6; i++) begin
            r = {8'(8'h60 + 8'(i)), 8'h61, 8'h62, 8'(8'h70 + 8'(i))};
            if (i < 4) expect_row(r, 1'b0);
            step(1'b1, r);
        end
        idle(4);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_valid", 64'(out_valid), 64'd1);
        d0 = done_cnt;
        out_ready = 1'b1;
        wait_done(d0, 20);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);
        chk("t3_ovf_sticky", 64'(overflow), 64'd1);

        // Five rows while out_ready toggles every cycle.
        out_ready = 1'b0;
        toggle = 1'b1;
        start(5);
        chk("t4_ovf_clear", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) begin
            r = {8'(8'hA0 + 8'(i)), 8'(8'hB0 + 8'(i)), 8'(8'hC0 + 8'(i)), 8'(8'hD0 + 8'(i))};
            expect_row(r, i == 4);
            step(1'b1, r);
        end
        d0 = done_cnt;
        wait_done(d0, 40);
        toggle = 1'b0;
        out_ready = 1'b1;
        chk("t4_overflow", 64'(overflow), 64'd0);
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // Extra in_valid beyond rows and cmd_start while busy are ignored.
        start(2);
        for (int i = 0; i < 4; i++) begin
            r = {8'(8'h01 + 8'(i)), 8'h02, 8'h03, 8'(8'h04 + 8'(i))};
            if (i < 2) expect_row(r, i == 1);
            step(1'b1, r);
        end
        start(1);
        d0 = done_cnt;
        wait_done(d0, 20);
        idle(4);
        chk("t5_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        // Zero-row frame.
        start(0);
        chk("t5_zero_d1", 64'(done), 64'd0);
        chk("t5_zero_busy", 64'(busy), 64'd1);
        idle(1);
        chk("t5_zero_d2", 64'(done), 64'd1);
        idle(1);
        chk("t5_zero_d3", 64'(done), 64'd0);
        chk("t5_zero_idle", 64'(busy), 64'd0);

        // Reset mid-frame with two rows buffered.
        out_ready = 1'b0;
        start(4);
        for (int i = 0; i < 2; i++) begin
            r = {8'h55, 8'(8'h66 + 8'(i)), 8'h77, 8'h88};
            expect_row(r, 1'b0);
            step(1'b1, r);
        end
        idle(4);
        chk("t6_buffered", 64'(out_valid), 64'd1);
        d0 = done_cnt;
        reset = 1'b1;
        idle(1);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        idle(4);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);

        // Negative and positive lane values.
        out_ready = 1'b1;
        start(1);
        r = {8'hF0, 8'h7F, 8'h80, 8'h01};
        expect_row(r, 1'b1);
        step(1'b1, r);
        d0 = done_cnt;
        wait_done(d0, 20);
        chk("end_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
